// File: rtl/mac_pkg.sv
// Shared definitions for the multiply-accumulate sequencing controller:
// state encodings and default parameter values.
package mac_pkg;

   localparam int DEF_LEN_W   = 8;
   localparam int DEF_ADD_LAT = 1;

   // Codes 6 and 7 are unused and recover to S_IDLE.
   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_CLR  = 3'd1,
      S_LOAD = 3'd2,
      S_MUL  = 3'd3,
      S_ACC  = 3'd4,
      S_DONE = 3'd5
   } state_t;

endpackage

// File: rtl/mac_lat_counter.sv
// Loadable down-counter timing the accumulate dwell; expired is high once
// the count has reached zero and stays there until the next load.
module mac_lat_counter #(
   parameter int CNT_W = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             dec,
   output logic             expired
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (dec && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired = (cnt_q == '0);

endmodule

// File: rtl/mac_seq_controller.sv
// Sequencer for an N-term dot product: per term it takes one operand pair,
// runs the multiplier, then triggers the adder and waits ADD_LAT cycles.
module mac_seq_controller
   import mac_pkg::*;
#(
   parameter int LEN_W   = DEF_LEN_W,
   parameter int ADD_LAT = DEF_ADD_LAT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [LEN_W-1:0] len,
   input  logic             clear_acc,
   input  logic             abort,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             ldA,
   output logic             ldB,
   output logic             start_mul,
   input  logic             valid_mul,
   output logic             clr_acc,
   output logic             ldacc,
   output logic             start_adder,
   output logic             busy,
   output logic             done,
   output logic [LEN_W-1:0] idx,
   output logic [2:0]       state
);

   localparam int               CNT_W    = (ADD_LAT > 1) ? $clog2(ADD_LAT) : 1;
   localparam logic [CNT_W-1:0] ACC_LOAD = CNT_W'(ADD_LAT - 1);

   state_t           state_q, state_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic [LEN_W-1:0] idx_q, idx_d;
   logic             mul_first_q, mul_first_d;
   logic             acc_first_q, acc_first_d;
   logic [LEN_W-1:0] last_idx;
   logic             acc_expired;

   // Last index is only consulted in ACC, where len_q is known to be non-zero.
   assign last_idx = len_q - 1'b1;

   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      idx_d   = idx_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               len_d = len;
               idx_d = '0;
               if (len == '0) begin
                  state_d = S_DONE;
               end else if (clear_acc) begin
                  state_d = S_CLR;
               end else begin
                  state_d = S_LOAD;
               end
            end
         end
         S_CLR:  state_d = S_LOAD;
         S_LOAD: if (in_valid) state_d = S_MUL;
         S_MUL:  if (valid_mul) state_d = S_ACC;
         S_ACC: begin
            if (acc_expired) begin
               if (idx_q == last_idx) begin
                  state_d = S_DONE;
               end else begin
                  idx_d   = idx_q + 1'b1;
                  state_d = S_LOAD;
               end
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      if (abort && (state_q != S_IDLE)) begin
         state_d = S_IDLE;
         idx_d   = '0;
      end

      mul_first_d = (state_d == S_MUL) && (state_q != S_MUL);
      acc_first_d = (state_d == S_ACC) && (state_q != S_ACC);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         len_q       <= '0;
         idx_q       <= '0;
         mul_first_q <= 1'b0;
         acc_first_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         len_q       <= len_d;
         idx_q       <= idx_d;
         mul_first_q <= mul_first_d;
         acc_first_q <= acc_first_d;
      end
   end

   mac_lat_counter #(
      .CNT_W(CNT_W)
   ) u_lat_counter (
      .clk     (clk),
      .rst     (rst),
      .load    (acc_first_d),
      .load_val(ACC_LOAD),
      .dec     (state_q == S_ACC),
      .expired (acc_expired)
   );

   // Operand handshake: a pair transfers in any cycle with in_valid && in_ready;
   // ldA/ldB mark exactly that cycle, so they follow in_valid combinationally.
   assign in_ready    = (state_q == S_LOAD);
   assign ldA         = in_ready && in_valid;
   assign ldB         = in_ready && in_valid;
   assign start_mul   = (state_q == S_MUL) && mul_first_q;
   assign clr_acc     = (state_q == S_CLR);
   assign ldacc       = (state_q == S_ACC) && acc_first_q;
   assign start_adder = (state_q == S_ACC) && acc_first_q;
   assign busy        = (state_q != S_IDLE);
   assign done        = (state_q == S_DONE);
   assign idx         = idx_q;
   assign state       = state_q;

endmodule

// File: tb/tb_mac_seq_controller.sv
// Bench for mac_seq_controller: two instances (ADD_LAT=1 and ADD_LAT=3) share
// the control inputs, each with its own behavioural multiplier.
module tb_mac_seq_controller;
   import mac_pkg::*;

   localparam int LEN_W = 8;

   logic             clk = 1'b0;
   logic             rst;
   logic             start, clear_acc, abort, in_valid;
   logic [LEN_W-1:0] len;

   logic             a_in_ready, a_ldA, a_ldB, a_start_mul, a_valid_mul, a_clr_acc;
   logic             a_ldacc, a_start_adder, a_busy, a_done;
   logic [LEN_W-1:0] a_idx;
   logic [2:0]       a_state;
   logic             b_in_ready, b_ldA, b_ldB, b_start_mul, b_valid_mul, b_clr_acc;
   logic             b_ldacc, b_start_adder, b_busy, b_done;
   logic [LEN_W-1:0] b_idx;
   logic [2:0]       b_state;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int mul_lat = 2;

   logic [LEN_W-1:0] exp_idx_q[$];
   logic [31:0]      exp_cyc_q[$];
   logic [LEN_W-1:0] obs_idx_q[$];
   logic [31:0]      obs_cyc_q[$];
   logic [LEN_W-1:0] e_ix, o_ix;
   logic [31:0]      e_cy, o_cy;

   int r_done_cyc, r_done_cnt, r_ldacc_cnt, r_clr_cnt, r_clr_cyc, r_ld_cnt, r_ld_cyc;
   int r_smul_cnt, r_smul_cyc, r_load_n, r_mul_n, r_acc_n, r_sa_diff;
   int r_abort_cyc, r_post_st, r_post_ix, r_post_act, r_busy1, r_busy_post;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   mac_seq_controller #(.LEN_W(LEN_W), .ADD_LAT(1)) dut_a (
      .clk(clk), .rst(rst), .start(start), .len(len), .clear_acc(clear_acc),
      .abort(abort), .in_valid(in_valid), .in_ready(a_in_ready), .ldA(a_ldA),
      .ldB(a_ldB), .start_mul(a_start_mul), .valid_mul(a_valid_mul),
      .clr_acc(a_clr_acc), .ldacc(a_ldacc), .start_adder(a_start_adder),
      .busy(a_busy), .done(a_done), .idx(a_idx), .state(a_state)
   );

   mac_seq_controller #(.LEN_W(LEN_W), .ADD_LAT(3)) dut_b (
      .clk(clk), .rst(rst), .start(start), .len(len), .clear_acc(clear_acc),
      .abort(abort), .in_valid(in_valid), .in_ready(b_in_ready), .ldA(b_ldA),
      .ldB(b_ldB), .start_mul(b_start_mul), .valid_mul(b_valid_mul),
      .clr_acc(b_clr_acc), .ldacc(b_ldacc), .start_adder(b_start_adder),
      .busy(b_busy), .done(b_done), .idx(b_idx), .state(b_state)
   );

   // Multiplier model: valid_mul arrives mul_lat cycles after start_mul.
   logic a_act, b_act;
   int   a_rem, b_rem;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         a_act <= 1'b0; a_rem <= 0;
      end else if (a_start_mul && mul_lat > 0) begin
         a_act <= 1'b1; a_rem <= mul_lat - 1;
      end else if (a_act) begin
         if (a_rem == 0) a_act <= 1'b0;
         else a_rem <= a_rem - 1;
      end
   end

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         b_act <= 1'b0; b_rem <= 0;
      end else if (b_start_mul && mul_lat > 0) begin
         b_act <= 1'b1; b_rem <= mul_lat - 1;
      end else if (b_act) begin
         if (b_rem == 0) b_act <= 1'b0;
         else b_rem <= b_rem - 1;
      end
   end

   assign a_valid_mul = (a_start_mul && mul_lat == 0) || (a_act && a_rem == 0);
   assign b_valid_mul = (b_start_mul && mul_lat == 0) || (b_act && b_rem == 0);

   task automatic do_reset();
      rst = 1'b1; start = 1'b0; len = '0; clear_acc = 1'b0; abort = 1'b0; in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input int n, input int base, input int m, input int si, input int sn);
      int p;
      p = 2 + m + 1;
      for (int k = 0; k < n; k++) begin
         exp_idx_q.push_back(k[LEN_W-1:0]);
         exp_cyc_q.push_back(32'(base + k * p + 2 + m + ((k >= si) ? sn : 0)));
      end
   endtask

   // Starts a sequence (cycle 0 = start cycle) and records what the selected DUT does.
   task automatic run(input bit sel, input int n, input bit clr, input int max_cyc,
                      input int stall_idx, input int stall_n, input int abort_idx,
                      input int restart_at);
      logic             s_done, s_ldacc, s_sa, s_clr, s_ld, s_smul, s_busy;
      logic [2:0]       s_st;
      logic [LEN_W-1:0] s_ix;
      int               left;
      r_done_cyc = -1; r_done_cnt = 0; r_ldacc_cnt = 0; r_clr_cnt = 0; r_clr_cyc = -1;
      r_ld_cnt = 0; r_ld_cyc = -1; r_smul_cnt = 0; r_smul_cyc = -1; r_load_n = 0;
      r_mul_n = 0; r_acc_n = 0; r_sa_diff = 0; r_abort_cyc = -1; r_post_st = -1;
      r_post_ix = -1; r_post_act = -1; r_busy1 = -1; r_busy_post = -1;
      obs_idx_q.delete(); obs_cyc_q.delete();
      left = stall_n;
      start = 1'b1; len = n[LEN_W-1:0]; clear_acc = clr; in_valid = 1'b1; abort = 1'b0;
      for (int c = 0; c < max_cyc; c++) begin
         @(negedge clk);
         s_done  = sel ? b_done : a_done;
         s_ldacc = sel ? b_ldacc : a_ldacc;
         s_sa    = sel ? b_start_adder : a_start_adder;
         s_clr   = sel ? b_clr_acc : a_clr_acc;
         s_ld    = sel ? (b_ldA | b_ldB) : (a_ldA | a_ldB);
         s_smul  = sel ? b_start_mul : a_start_mul;
         s_busy  = sel ? b_busy : a_busy;
         s_st    = sel ? b_state : a_state;
         s_ix    = sel ? b_idx : a_idx;
         if (s_done) begin r_done_cnt++; if (r_done_cyc < 0) r_done_cyc = c; end
         if (s_ldacc) begin r_ldacc_cnt++; obs_idx_q.push_back(s_ix); obs_cyc_q.push_back(32'(c)); end
         if (s_sa !== s_ldacc) r_sa_diff++;
         if (s_clr) begin r_clr_cnt++; if (r_clr_cyc < 0) r_clr_cyc = c; end
         if (s_ld) begin r_ld_cnt++; if (r_ld_cyc < 0) r_ld_cyc = c; end
         if (s_smul) begin r_smul_cnt++; if (r_smul_cyc < 0) r_smul_cyc = c; end
         if (s_st == S_LOAD) r_load_n++;
         if (s_st == S_MUL) r_mul_n++;
         if (s_st == S_ACC) r_acc_n++;
         if (c == 1) r_busy1 = int'(s_busy);
         if (r_done_cyc >= 0 && c == r_done_cyc + 1) r_busy_post = int'(s_busy);
         if (r_abort_cyc >= 0 && c == r_abort_cyc + 1) begin
            r_post_st  = int'(s_st);
            r_post_ix  = int'(s_ix);
            r_post_act = int'(s_done | s_ldacc | s_clr | s_ld | s_smul | s_busy);
         end
         if (r_done_cyc >= 0 && c >= r_done_cyc + 1) break;
         @(posedge clk);
         #1;
         start = 1'b0; abort = 1'b0;
         if (c + 1 == restart_at) begin start = 1'b1; len = 8'd7; clear_acc = 1'b1; end
         s_st = sel ? b_state : a_state;
         s_ix = sel ? b_idx : a_idx;
         in_valid = 1'b1;
         if (s_st == S_LOAD && int'(s_ix) == stall_idx && left > 0) begin
            in_valid = 1'b0; left--;
         end
         if (abort_idx >= 0 && r_abort_cyc < 0 && s_st == S_MUL && int'(s_ix) == abort_idx) begin
            abort = 1'b1; r_abort_cyc = c + 1;
         end
      end
      start = 1'b0; abort = 1'b0; in_valid = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (a_state !== 3'd0) begin failures++; $display("FAIL reset_state: got %0d expected 0", a_state); end
      checks++;
      if (a_idx !== '0) begin failures++; $display("FAIL reset_idx: got %0d expected 0", a_idx); end
      checks++;
      if ({a_busy, a_done, a_in_ready, a_clr_acc, a_ldacc, a_start_mul} !== 6'b0) begin
         failures++; $display("FAIL reset_outputs: got %b expected 000000",
            {a_busy, a_done, a_in_ready, a_clr_acc, a_ldacc, a_start_mul});
      end
   endtask

   task automatic test_single_clear();
      do_reset();
      mul_lat = 2;
      push_exp(1, 2, 2, 99, 0);
      run(1'b0, 1, 1'b1, 30, -1, 0, -1, -1);
      checks++;
      if (r_clr_cyc !== 1) begin failures++; $display("FAIL single_clr_cycle: got %0d expected 1", r_clr_cyc); end
      checks++;
      if (r_ld_cyc !== 2) begin failures++; $display("FAIL single_ld_cycle: got %0d expected 2", r_ld_cyc); end
      checks++;
      if (r_smul_cyc !== 3) begin failures++; $display("FAIL single_smul_cycle: got %0d expected 3", r_smul_cyc); end
      checks++;
      if (r_done_cyc !== 7) begin failures++; $display("FAIL single_done_cycle: got %0d expected 7", r_done_cyc); end
      checks++;
      if (r_busy1 !== 1 || r_busy_post !== 0) begin
         failures++; $display("FAIL single_busy: got %0d/%0d expected 1/0", r_busy1, r_busy_post);
      end
      checks++;
      if (r_sa_diff !== 0) begin failures++; $display("FAIL single_start_adder: got %0d differing cycles expected 0", r_sa_diff); end
      while (exp_idx_q.size() > 0) begin
         e_ix = exp_idx_q.pop_front(); e_cy = exp_cyc_q.pop_front();
         checks++;
         if (obs_idx_q.size() == 0) begin
            failures++; $display("FAIL single_sb: no ldacc seen, expected idx %0d at cycle %0d", e_ix, e_cy);
         end else begin
            o_ix = obs_idx_q.pop_front(); o_cy = obs_cyc_q.pop_front();
            if (o_ix !== e_ix || o_cy !== e_cy) begin
               failures++; $display("FAIL single_sb: got idx %0d at cycle %0d expected idx %0d at cycle %0d", o_ix, o_cy, e_ix, e_cy);
            end
         end
      end
   endtask

   task automatic test_three_noclear();
      do_reset();
      mul_lat = 2;
      push_exp(3, 1, 2, 99, 0);
      run(1'b0, 3, 1'b0, 60, -1, 0, -1, -1);
      checks++;
      if (r_clr_cnt !== 0) begin failures++; $display("FAIL three_clr_count: got %0d expected 0", r_clr_cnt); end
      checks++;
      if (r_ldacc_cnt !== 3) begin failures++; $display("FAIL three_ldacc_count: got %0d expected 3", r_ldacc_cnt); end
      checks++;
      if (r_done_cyc !== 16) begin failures++; $display("FAIL three_done_cycle: got %0d expected 16", r_done_cyc); end
      while (exp_idx_q.size() > 0) begin
         e_ix = exp_idx_q.pop_front(); e_cy = exp_cyc_q.pop_front();
         checks++;
         if (obs_idx_q.size() == 0) begin
            failures++; $display("FAIL three_sb: no ldacc seen, expected idx %0d at cycle %0d", e_ix, e_cy);
         end else begin
            o_ix = obs_idx_q.pop_front(); o_cy = obs_cyc_q.pop_front();
            if (o_ix !== e_ix || o_cy !== e_cy) begin
               failures++; $display("FAIL three_sb: got idx %0d at cycle %0d expected idx %0d at cycle %0d", o_ix, o_cy, e_ix, e_cy);
            end
         end
      end
   endtask

   task automatic test_backpressure();
      int d0;
      do_reset();
      mul_lat = 0;
      run(1'b0, 3, 1'b0, 40, -1, 0, -1, -1);
      d0 = r_done_cyc;
      checks++;
      if (d0 !== 10) begin failures++; $display("FAIL bp_unstalled_done: got %0d expected 10", d0); end
      do_reset();
      push_exp(3, 1, 0, 1, 4);
      run(1'b0, 3, 1'b0, 40, 1, 4, -1, -1);
      checks++;
      if (r_done_cyc !== 14) begin failures++; $display("FAIL bp_done_cycle: got %0d expected 14", r_done_cyc); end
      checks++;
      if (r_done_cyc - d0 !== 4) begin failures++; $display("FAIL bp_delay: got %0d expected 4", r_done_cyc - d0); end
      checks++;
      if (r_load_n !== 7) begin failures++; $display("FAIL bp_load_cycles: got %0d expected 7", r_load_n); end
      checks++;
      if (r_mul_n !== 3) begin failures++; $display("FAIL bp_mul_cycles: got %0d expected 3", r_mul_n); end
      checks++;
      if (r_ld_cnt !== 3) begin failures++; $display("FAIL bp_ld_count: got %0d expected 3", r_ld_cnt); end
      while (exp_idx_q.size() > 0) begin
         e_ix = exp_idx_q.pop_front(); e_cy = exp_cyc_q.pop_front();
         checks++;
         if (obs_idx_q.size() == 0) begin
            failures++; $display("FAIL bp_sb: no ldacc seen, expected idx %0d at cycle %0d", e_ix, e_cy);
         end else begin
            o_ix = obs_idx_q.pop_front(); o_cy = obs_cyc_q.pop_front();
            if (o_ix !== e_ix || o_cy !== e_cy) begin
               failures++; $display("FAIL bp_sb: got idx %0d at cycle %0d expected idx %0d at cycle %0d", o_ix, o_cy, e_ix, e_cy);
            end
         end
      end
   endtask

   task automatic test_zero_len_busy_start();
      do_reset();
      mul_lat = 2;
      run(1'b0, 0, 1'b1, 10, -1, 0, -1, -1);
      checks++;
      if (r_done_cyc !== 1) begin failures++; $display("FAIL zero_done_cycle: got %0d expected 1", r_done_cyc); end
      checks++;
      if (r_ld_cnt + r_clr_cnt + r_smul_cnt + r_ldacc_cnt !== 0) begin
         failures++; $display("FAIL zero_activity: got %0d datapath pulses expected 0",
            r_ld_cnt + r_clr_cnt + r_smul_cnt + r_ldacc_cnt);
      end
      checks++;
      if (r_busy1 !== 1) begin failures++; $display("FAIL zero_busy: got %0d expected 1", r_busy1); end
      do_reset();
      push_exp(3, 1, 2, 99, 0);
      run(1'b0, 3, 1'b0, 60, -1, 0, -1, 8);
      checks++;
      if (r_done_cyc !== 16) begin failures++; $display("FAIL busy_start_done: got %0d expected 16", r_done_cyc); end
      checks++;
      if (r_clr_cnt !== 0 || r_ldacc_cnt !== 3) begin
         failures++; $display("FAIL busy_start_counts: got clr %0d ldacc %0d expected clr 0 ldacc 3", r_clr_cnt, r_ldacc_cnt);
      end
      while (exp_idx_q.size() > 0) begin
         e_ix = exp_idx_q.pop_front(); e_cy = exp_cyc_q.pop_front();
         checks++;
         if (obs_idx_q.size() == 0) begin
            failures++; $display("FAIL busy_start_sb: no ldacc seen, expected idx %0d at cycle %0d", e_ix, e_cy);
         end else begin
            o_ix = obs_idx_q.pop_front(); o_cy = obs_cyc_q.pop_front();
            if (o_ix !== e_ix || o_cy !== e_cy) begin
               failures++; $display("FAIL busy_start_sb: got idx %0d at cycle %0d expected idx %0d at cycle %0d", o_ix, o_cy, e_ix, e_cy);
            end
         end
      end
   endtask

   task automatic test_abort();
      do_reset();
      mul_lat = 2;
      run(1'b0, 3, 1'b1, 40, -1, 0, 1, -1);
      checks++;
      if (r_abort_cyc !== 8) begin failures++; $display("FAIL abort_cycle: got %0d expected 8", r_abort_cyc); end
      checks++;
      if (r_post_st !== 0 || r_post_ix !== 0) begin
         failures++; $display("FAIL abort_next_state: got state %0d idx %0d expected 0/0", r_post_st, r_post_ix);
      end
      checks++;
      if (r_post_act !== 0) begin failures++; $display("FAIL abort_next_outputs: got %0d expected 0", r_post_act); end
      checks++;
      if (r_done_cnt !== 0 || r_ldacc_cnt !== 1) begin
         failures++; $display("FAIL abort_counts: got done %0d ldacc %0d expected 0/1", r_done_cnt, r_ldacc_cnt);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      mul_lat = 2;
      start = 1'b1; len = 8'd3; clear_acc = 1'b0; in_valid = 1'b1;
      for (int i = 0; i < 20 && a_state != S_ACC; i++) begin
         @(posedge clk);
         #1 start = 1'b0;
      end
      checks++;
      if (a_state !== S_ACC) begin
         failures++; $display("FAIL rst_mid_reach_acc: got state %0d expected 4", a_state);
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({a_in_ready, a_ldA, a_ldB, a_start_mul, a_clr_acc, a_ldacc, a_start_adder,
           a_busy, a_done, a_idx, a_state} !== '0) begin
         failures++; $display("FAIL rst_mid_outputs: got state %0d idx %0d busy %0d ldacc %0d expected all 0",
            a_state, a_idx, a_busy, a_ldacc);
      end
      start = 1'b0; in_valid = 1'b0;
      @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_max_count();
      do_reset();
      mul_lat = 0;
      push_exp(255, 2, 0, 999, 0);
      // ADD_LAT=3 instance: P = 2 + 0 + 3 = 5
      for (int k = 0; k < 255; k++) exp_cyc_q[k] = 32'(2 + k * 5 + 2);
      run(1'b1, 255, 1'b1, 1400, -1, 0, -1, -1);
      checks++;
      if (r_ldacc_cnt !== 255) begin failures++; $display("FAIL max_ldacc_count: got %0d expected 255", r_ldacc_cnt); end
      checks++;
      if (r_acc_n !== 765) begin failures++; $display("FAIL max_acc_cycles: got %0d expected 765", r_acc_n); end
      checks++;
      if (r_done_cyc !== 1277) begin failures++; $display("FAIL max_done_cycle: got %0d expected 1277", r_done_cyc); end
      checks++;
      if (r_sa_diff !== 0) begin failures++; $display("FAIL max_start_adder: got %0d differing cycles expected 0", r_sa_diff); end
      while (exp_idx_q.size() > 0) begin
         e_ix = exp_idx_q.pop_front(); e_cy = exp_cyc_q.pop_front();
         checks++;
         if (obs_idx_q.size() == 0) begin
            failures++; $display("FAIL max_sb: no ldacc seen, expected idx %0d at cycle %0d", e_ix, e_cy);
         end else begin
            o_ix = obs_idx_q.pop_front(); o_cy = obs_cyc_q.pop_front();
            if (o_ix !== e_ix || o_cy !== e_cy) begin
               failures++; $display("FAIL max_sb: got idx %0d at cycle %0d expected idx %0d at cycle %0d", o_ix, o_cy, e_ix, e_cy);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_clear();
      test_three_noclear();
      test_backpressure();
      test_zero_len_busy_start();
      test_abort();
      test_reset_mid();
      test_max_count();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mac_seq_controller.md
# mac_seq_controller

Parametrised sequencing controller for the multiplier-accumulator datapath. It computes an N-term dot product: for each of `len` operand pairs it performs a valid/ready load, waits on a variable-latency multiplier, then triggers accumulation and waits a fixed adder latency. Compared with the single-shot MAC controller, it adds:

- a run-time term count;
- an optional accumulator clear at start, or continuation from the previous result;
- an operand handshake;
- a configurable adder latency;
- an abort input.

It sits between the system sequencer and the A/B operand registers, multiplier, adder and accumulator.

## Interface
Parameters:
- `LEN_W`, 8: width of the term count and index.
- `ADD_LAT`, 1: adder latency in cycles, at least 1.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  begin a sequence; sampled in IDLE only.
- `len`  in  LEN_W  number of terms; captured with `start`.
- `clear_acc`  in  1  mode, captured with `start`: 1 = clear accumulator first, 0 = accumulate onto the existing value.
- `abort`  in  1  synchronous cancel.
- `in_valid`  in  1  operand pair available.
- `in_ready`  out  1  controller accepts the operand pair.
- `ldA`, `ldB`  out  1 each  load the operand registers.
- `start_mul`  out  1  multiplier start pulse.
- `valid_mul`  in  1  multiplier result valid.
- `clr_acc`  out  1  synchronous accumulator clear.
- `ldacc`  out  1  accumulator load.
- `start_adder`  out  1  adder start.
- `busy`  out  1  state ≠ IDLE.
- `done`  out  1  one-cycle completion pulse.
- `idx`  out  LEN_W  index of the term in progress, starting at 0.
- `state`  out  3  current state, for debug.

## Operation
- States and encodings:
  - IDLE = 0
  - CLR = 1
  - LOAD = 2
  - MUL = 3
  - ACC = 4
  - DONE = 5
  - Codes 6 and 7 are illegal and go to IDLE on the next clock.
- **IDLE:** on `start`, capture `len` and `clear_acc` and set `idx` to 0. Then go to:
  - DONE if `len` = 0 (no datapath activity);
  - else CLR if `clear_acc` = 1;
  - else LOAD.
- **CLR:** `clr_acc` = 1 for one cycle, then go to LOAD.
- **LOAD:** `in_ready` = 1. `ldA` = `ldB` = `in_valid` (combinational, same cycle). On `in_valid`, go to MUL; otherwise stay.
- **MUL:** `start_mul` = 1 in the first MUL cycle only. Go to ACC in the cycle after `valid_mul` is sampled high. `valid_mul` is honoured in any MUL cycle, including the first. `valid_mul` outside MUL is ignored.
- **ACC:** `ldacc` = `start_adder` = 1 in the first ACC cycle only. ACC lasts exactly ADD_LAT cycles. Then:
  - if `idx` = `len`−1, go to DONE;
  - else increment `idx` and go to LOAD.
- **DONE:** `done` = 1 for one cycle, then go to IDLE.
- **abort:** in any non-IDLE state, the next state is IDLE and `idx` is cleared to 0. No `done` is produced and no output pulses in the cycle after. `abort` has priority over every other transition.
- **start while busy:** ignored. `len` and `clear_acc` are not re-captured.
- **Full-range count:** `len` = 2^LEN_W−1 runs to completion. `idx` never wraps, because the comparison against `len`−1 is made before incrementing.
- **Reset:** all outputs are 0, `state` is IDLE and `idx` is 0, immediately on `rst` assertion, including mid-sequence.

## Timing
- Define:
  - M = cycles from the `start_mul` cycle to the `valid_mul` cycle (M ≥ 0);
  - A = ADD_LAT;
  - P = 2 + M + A, the per-term period with `in_valid` held high.
- With `start` sampled at cycle 0:
  - `done` is asserted at cycle 2 + N·P when `clear_acc` = 1;
  - `done` is asserted at cycle 1 + N·P when `clear_acc` = 0.
- Each cycle that `in_valid` is low during LOAD adds one cycle.
- `busy` rises the cycle after `start` and falls the cycle after `done`.
- `ldA`/`ldB` are combinational from state and `in_valid`. All other outputs are Moore, decoded from registered state plus the first-cycle flag.

## Structure
- Shared package `mac_pkg`:
  - state enum and encodings;
  - default `LEN_W` and `ADD_LAT` constants.
- One sub-module: `mac_lat_counter`, a loadable down-counter that times the ACC dwell. It takes a load value of ADD_LAT−1 and outputs `expired`.
- The `idx` counter and the first-cycle flags live in the top module.

## Test plan
- **Single term with clear:** `len`=1, `clear_acc`=1, `in_valid`=1, M=2, A=1, `start` at cycle 0. Expect `clr_acc` at cycle 1, `ldA`/`ldB` at cycle 2, `start_mul` at cycle 3, `ldacc` at cycle 6, `done` at cycle 7.
- **Three terms, no clear:** `len`=3, `clear_acc`=0, M=2, A=1. Expect `clr_acc` never asserted, `idx` stepping 0→1→2, three `ldacc` pulses, `done` at cycle 16.
- **Backpressure and zero-latency multiply:** `in_valid` low for 4 cycles in LOAD of term 1, and `valid_mul` in the same cycle as `start_mul` (M=0). Expect LOAD to dwell 5 cycles, MUL to last 1 cycle, and `done` delayed by exactly 4 cycles versus the unstalled run.
- **Zero length and busy start:** `len`=0 → `done` the cycle after `start`, with no `ld*`, `clr_acc`, `start_mul` or `ldacc` asserted. A `start` pulsed mid-run with a different `len` does not alter `idx` progression.
- **Abort and reset mid-run:** `abort` during MUL of term 2 → IDLE the next cycle, no `done`, `idx`=0. Asynchronous `rst` during ACC → all outputs 0 before the next edge.
- **ADD_LAT sweep and maximum count:** ADD_LAT=3 with `len`=2^LEN_W−1 (255). Expect ACC dwell of 3 cycles, `ldacc` pulsing only on the first ACC cycle, 255 `ldacc` pulses, and `idx` reaching 254 then DONE with no wrap.
